// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem reads and holds the IF/ID
// register. Redirects come from the decode-side copy of IF/ID (one bubble).
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  input  logic        stall,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] jtgt;
  logic [31:0] btgt;
  logic [31:0] redirect_pc;

  assign pc4      = pc + 32'd4;
  assign jtgt     = {ifid_npc[31:28], ifid_instr[25:0], 2'b00};
  assign btgt     = ifid_npc + {{14{ifid_instr[15]}}, ifid_instr[15:0], 2'b00};
  assign imemaddr = pc;
  assign imemREN  = (state == FETCH);
  assign halted   = (state == HALTED);

  always_comb begin
    redirect_pc = pc4;
    unique case (pc_sel)
      2'b01:   redirect_pc = jr_addr;
      2'b10:   redirect_pc = jtgt;
      2'b11:   redirect_pc = btgt;
      default: redirect_pc = pc4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= PC_INIT;
      ifid_instr <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
      state      <= IDLE;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          // First match wins; a redirect discards any word fetched this cycle.
          if (stall) begin
            pc <= pc;
          end else if (halt && ifid_valid) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            state      <= HALTED;
          end else if (ifid_valid && (pc_sel != 2'b00)) begin
            pc         <= redirect_pc;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
          end else if (ihit) begin
            ifid_instr <= imemload;
            ifid_npc   <= pc4;
            ifid_valid <= 1'b1;
            pc         <= pc4;
          end else begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID contents into
// a queue; a negedge monitor pops and compares each newly latched instruction.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] jr_addr = '0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .pc_sel(pc_sel),
    .jr_addr(jr_addr), .halt(halt), .stall(stall),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic stall_at_edge = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then settle just past the rising edge.
  task automatic cyc(input logic r, input logic h, input logic [31:0] w,
                     input logic [1:0] sel, input logic [31:0] jr,
                     input logic hl, input logic st);
    RST = r; ihit = h; imemload = w; pc_sel = sel; jr_addr = jr;
    halt = hl; stall = st;
    @(posedge CLK);
    #1;
  endtask

  task automatic hit(input logic [31:0] w, input logic [31:0] npc);
    exp_q.push_back({w, npc});
    cyc(1'b0, 1'b1, w, 2'b00, '0, 1'b0, 1'b0);
  endtask

  always @(posedge CLK) stall_at_edge <= stall;

  always @(negedge CLK) begin
    if (ifid_valid === 1'b1 && !stall_at_edge) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got instr %h npc %h expected none at %0t",
                 ifid_instr, ifid_npc, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("ifid_instr", ifid_instr, e[63:32]);
        chk("ifid_npc", ifid_npc, e[31:0]);
      end
    end
  end

  localparam logic [31:0] A  = 32'h2001_0001;
  localparam logic [31:0] B  = 32'h2002_0002;
  localparam logic [31:0] C  = 32'h2003_0003;
  localparam logic [31:0] D  = 32'h2004_0004;
  localparam logic [31:0] E  = 32'h2005_0005;
  localparam logic [31:0] BR = 32'h1000_FFFC;
  localparam logic [31:0] JI = 32'h0800_0040;
  localparam logic [31:0] JR = 32'h03E0_0008;
  localparam logic [31:0] JL = 32'h0800_0090;
  localparam logic [31:0] HW = 32'hFC00_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    // reset held two edges, then one dead IDLE cycle
    cyc(1'b1, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
    chk("rst_pc", imemaddr, 32'h0);
    chk("rst_ren", {31'b0, imemREN}, 32'd0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_npc", ifid_npc, 32'h0);
    cyc(1'b0, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
    chk("fetch_ren", {31'b0, imemREN}, 32'd1);
    chk("fetch_pc", imemaddr, 32'h0);

    // straight line
    hit(A, 32'h4);  chk("line_pc4", imemaddr, 32'h4);
    hit(B, 32'h8);  chk("line_pc8", imemaddr, 32'h8);
    hit(C, 32'hC);  chk("line_pc12", imemaddr, 32'hC);
    hit(D, 32'h10); chk("line_pc16", imemaddr, 32'h10);

    // three misses at 0x10; decode inputs must be ignored once IF/ID is empty
    cyc(1'b0, 1'b0, JUNK, 2'b00, '0, 1'b0, 1'b0);
    chk("miss_pc", imemaddr, 32'h10);
    chk("miss_valid", {31'b0, ifid_valid}, 32'd0);
    chk("miss_instr", ifid_instr, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, JUNK, 2'b10, 32'h0000_0400, 1'b1, 1'b0);
      chk("miss_pc_hold", imemaddr, 32'h10);
      chk("miss_valid_hold", {31'b0, ifid_valid}, 32'd0);
      chk("miss_not_halted", {31'b0, halted}, 32'd0);
    end
    exp_q.push_back({E, 32'h14});
    cyc(1'b0, 1'b1, E, 2'b11, '0, 1'b0, 1'b0);
    chk("after_miss_pc", imemaddr, 32'h14);

    // branch back: npc 0x20 + (-4 << 2) = 0x10
    hit(A, 32'h18);
    hit(B, 32'h1C);
    hit(BR, 32'h20);
    cyc(1'b0, 1'b1, JUNK, 2'b11, '0, 1'b0, 1'b0);
    chk("br_pc", imemaddr, 32'h10);
    chk("br_bubble", {31'b0, ifid_valid}, 32'd0);
    hit(JI, 32'h14);
    cyc(1'b0, 1'b1, JUNK, 2'b10, '0, 1'b0, 1'b0);
    chk("j_pc", imemaddr, 32'h100);
    chk("j_bubble", {31'b0, ifid_valid}, 32'd0);
    hit(JR, 32'h104);
    cyc(1'b0, 1'b1, JUNK, 2'b01, 32'h200, 1'b0, 1'b0);
    chk("jr_pc", imemaddr, 32'h200);

    // stall holds everything, redirect applied once stall drops
    hit(JL, 32'h204);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, JUNK, 2'b10, '0, 1'b0, 1'b1);
      chk("stall_pc", imemaddr, 32'h204);
      chk("stall_instr", ifid_instr, JL);
      chk("stall_valid", {31'b0, ifid_valid}, 32'd1);
      chk("stall_ren", {31'b0, imemREN}, 32'd1);
    end
    cyc(1'b0, 1'b1, JUNK, 2'b10, '0, 1'b0, 1'b0);
    chk("unstall_pc", imemaddr, 32'h240);
    chk("unstall_bubble", {31'b0, ifid_valid}, 32'd0);

    // wrap: PC 0xFFFF_FFFC + 4 -> 0
    hit(JR, 32'h244);
    cyc(1'b0, 1'b1, JUNK, 2'b01, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("wrap_top", imemaddr, 32'hFFFF_FFFC);
    hit(C, 32'h0);
    chk("wrap_pc", imemaddr, 32'h0);

    // halt
    hit(HW, 32'h4);
    cyc(1'b0, 1'b1, JUNK, 2'b00, '0, 1'b1, 1'b0);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_ren", {31'b0, imemREN}, 32'd0);
    chk("halt_pc", imemaddr, 32'h4);
    chk("halt_valid", {31'b0, ifid_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, JUNK, 2'b10, 32'h800, 1'b0, 1'b0);
      chk("halted_pc", imemaddr, 32'h4);
      chk("halted_npc", ifid_npc, 32'h4);
      chk("halted_flag", {31'b0, halted}, 32'd1);
    end

    // reset out of HALTED
    cyc(1'b1, 1'b1, JUNK, 2'b00, '0, 1'b0, 1'b0);
    chk("rerst_pc", imemaddr, 32'h0);
    chk("rerst_halted", {31'b0, halted}, 32'd0);
    chk("rerst_ren", {31'b0, imemREN}, 32'd0);
    cyc(1'b0, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
    chk("rerst_fetch", {31'b0, imemREN}, 32'd1);
    hit(D, 32'h4);
    cyc(1'b0, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
